// File: rtl/pathfinding_pkg.sv
// pathfinding_pkg: shared memory ids, widths, coordinate type and reader states
package pathfinding_pkg;
   localparam logic [2:0] MEM_ID_X = 3'd0;
   localparam logic [2:0] MEM_ID_Y = 3'd1;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   typedef struct packed {
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
   } coord_t;
   typedef enum logic [2:0] {IDLE, RD_X, RD_Y, CAP_Y, OUT, FIN} reader_state_t;
endpackage

// File: rtl/coordinate_reader.sv
// coordinate_reader: streams stored (x,y) pairs from X/Y memories over valid/ready; COORD_READER_END_MARKER_EN stops at an all-ones pair
module coordinate_reader #(
   parameter int ADDR_W = pathfinding_pkg::ADDR_W,
   parameter int DATA_W = pathfinding_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] count,
   output logic [2:0]        mem_id,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] xmem_q,
   input  logic [DATA_W-1:0] ymem_q,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);
   import pathfinding_pkg::*;
   reader_state_t state, state_d;
   logic [ADDR_W-1:0] index, count_q;
   logic [DATA_W-1:0] x_q, y_q;
   assign mem_data = '0;
   assign mem_wren = 1'b0;
   assign out_x = x_q;
   assign out_y = y_q;
   // state register, pair index and capture registers; x lands in RD_Y and y in CAP_Y because reads take one cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         index <= '0;
         count_q <= '0;
         x_q <= '0;
         y_q <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && start) begin
            index <= '0;
            count_q <= count;
         end
         if (state == RD_Y) x_q <= xmem_q;
         if (state == CAP_Y) y_q <= ymem_q;
         if (state == OUT && out_ready && state_d == RD_X) index <= index + 1'b1;
      end
   // next state and state-decoded outputs; memory bus parks on X/address 0 outside a pair read
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = (count == '0) ? FIN : RD_X;
         RD_X:    state_d = RD_Y;
         RD_Y:    state_d = CAP_Y;
`ifdef COORD_READER_END_MARKER_EN
         CAP_Y:   state_d = (&x_q && &ymem_q) ? FIN : OUT;
`else
         CAP_Y:   state_d = OUT;
`endif
         OUT:     if (out_ready) state_d = (index == count_q - 1'b1) ? FIN : RD_X;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy = state != IDLE;
      done = state == FIN;
      out_valid = state == OUT;
      mem_id = (state == RD_Y) ? MEM_ID_Y : MEM_ID_X;
      mem_address = (state == IDLE || state == FIN) ? '0 : index;
   end
endmodule

// File: tb/tb_coordinate_reader.sv
// tb_coordinate_reader: directed self-checking bench for coordinate_reader
module tb_coordinate_reader;
   import pathfinding_pkg::*;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic [7:0] count = 8'd0;
   logic [2:0] mem_id;
   logic [7:0] mem_address, mem_data, xmem_q, ymem_q, out_x, out_y;
   logic mem_wren, out_valid, busy, done;
   logic [7:0] xmem [256];
   logic [7:0] ymem [256];
   logic [7:0] cap_x[$], cap_y[$];
   int checks = 0, errors = 0, bus_bad = 0, done_cnt = 0, valid_cnt = 0;

   coordinate_reader dut (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .mem_id(mem_id), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .xmem_q(xmem_q), .ymem_q(ymem_q),
      .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      xmem_q <= xmem[mem_address];
      ymem_q <= ymem[mem_address];
   end

   always @(negedge clk) begin
      #4;
      if (mem_wren !== 1'b0 || mem_data !== 8'd0) bus_bad++;
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1) valid_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         cap_x.push_back(out_x);
         cap_y.push_back(out_y);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "timeout");
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      repeat (budget) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic load(input logic [7:0] x0, x1, x2, y0, y1, y2);
      xmem[0] = x0; xmem[1] = x1; xmem[2] = x2;
      ymem[0] = y0; ymem[1] = y1; ymem[2] = y2;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {busy, done, out_valid}); end
      checks++;
      if ({mem_id, mem_address} !== {MEM_ID_X, 8'd0}) begin errors++; $display("FAIL reset_bus: got id=%0d addr=%0d required 0/0", mem_id, mem_address); end
      checks++;
      if ({out_x, out_y} !== 16'd0) begin errors++; $display("FAIL reset_xy: got %0h/%0h required 0/0", out_x, out_y); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_wait: busy=%b required 0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] ex [3], ey [3];
      int d0;
      bit ok;
      ex = '{8'd5, 8'd6, 8'd7};
      ey = '{8'd9, 8'd8, 8'd7};
      load(5, 6, 7, 9, 8, 7);
      count = 8'd3; out_ready = 1'b1;
      cap_x.delete(); cap_y.delete();
      d0 = done_cnt;
      pulse_start();
      checks++;
      if ({busy, mem_id, mem_address} !== {1'b1, MEM_ID_X, 8'd0}) begin errors++; $display("FAIL basic_rdx: got busy=%b id=%0d addr=%0d required 1/0/0", busy, mem_id, mem_address); end
      @(negedge clk);
      checks++;
      if ({mem_id, mem_address} !== {MEM_ID_Y, 8'd0}) begin errors++; $display("FAIL basic_rdy: got id=%0d addr=%0d required 1/0", mem_id, mem_address); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
      @(negedge clk);
      checks++;
      if ({out_valid, out_x, out_y} !== {1'b1, 8'd5, 8'd9}) begin errors++; $display("FAIL basic_first_valid: got v=%b x=%0d y=%0d required 1/5/9", out_valid, out_x, out_y); end
      wait_done(40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_done_timeout: done not seen, required within 40 cycles"); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_end_idle: got busy=%b done=%b required 0/0", busy, done); end
      checks++;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0); end
      checks++;
      if (cap_x.size() !== 3) begin errors++; $display("FAIL basic_pair_count: got %0d required 3", cap_x.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++;
         if ({cap_x[i], cap_y[i]} !== {ex[i], ey[i]}) begin errors++; $display("FAIL basic_pair%0d: got (%0d,%0d) required (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]); end
      end
   endtask

   task automatic test_zero_count();
      int d0, v0;
      count = 8'd0;
      cap_x.delete(); cap_y.delete();
      d0 = done_cnt; v0 = valid_cnt;
      pulse_start();
      checks++;
      if ({done, busy, out_valid, mem_address} !== {3'b110, 8'd0}) begin errors++; $display("FAIL zero_fin: got done=%b busy=%b valid=%b addr=%0d required 1/1/0/0", done, busy, out_valid, mem_address); end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_idle: got done=%b busy=%b required 0/0", done, busy); end
      checks++;
      if (done_cnt - d0 !== 1 || valid_cnt !== v0) begin errors++; $display("FAIL zero_counts: got done=%0d valid=%0d required 1/0", done_cnt - d0, valid_cnt - v0); end
   endtask

   task automatic test_stall();
      bit ok;
      load(5, 6, 7, 9, 8, 7);
      count = 8'd2; out_ready = 1'b0;
      cap_x.delete(); cap_y.delete();
      pulse_start();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({out_valid, out_x, out_y, mem_address, dut.index} !== {1'b1, 8'd5, 8'd9, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL stall_hold%0d: got v=%b x=%0d y=%0d addr=%0d idx=%0d required 1/5/9/0/0", i, out_valid, out_x, out_y, mem_address, dut.index);
         end
         @(negedge clk);
      end
      checks++;
      if (cap_x.size() !== 0) begin errors++; $display("FAIL stall_no_pair: got %0d pairs required 0", cap_x.size()); end
      out_ready = 1'b1;
      wait_done(40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_done_timeout: done not seen, required within 40 cycles"); end
      @(negedge clk);
      checks++;
      if (cap_x.size() !== 2) begin errors++; $display("FAIL stall_pair_count: got %0d required 2", cap_x.size()); end
      else begin
         checks++;
         if ({cap_x[0], cap_y[0], cap_x[1], cap_y[1]} !== {8'd5, 8'd9, 8'd6, 8'd8}) begin
            errors++;
            $display("FAIL stall_pairs: got (%0d,%0d)(%0d,%0d) required (5,9)(6,8)", cap_x[0], cap_y[0], cap_x[1], cap_y[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int v0;
      bit ok;
      load(5, 6, 7, 9, 8, 7);
      count = 8'd3; out_ready = 1'b1;
      pulse_start();
      repeat (5) @(negedge clk);
      checks++;
      if (dut.state !== RD_Y || mem_address !== 8'd1) begin errors++; $display("FAIL midrst_pre: got state=%0d addr=%0d required RD_Y/1", dut.state, mem_address); end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (dut.state !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d required IDLE", dut.state); end
      checks++;
      if ({busy, done, out_valid, mem_id, mem_address, out_x, out_y} !== 30'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got b=%b d=%b v=%b id=%0d addr=%0d x=%0d y=%0d required all 0", busy, done, out_valid, mem_id, mem_address, out_x, out_y);
      end
      @(negedge clk) reset = 1'b0;
      cap_x.delete(); cap_y.delete();
      v0 = valid_cnt;
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid_cnt !== v0) begin errors++; $display("FAIL midrst_no_partial: got busy=%b valid_cycles=%0d required 0/0", busy, valid_cnt - v0); end
      pulse_start();
      checks++;
      if ({mem_id, mem_address} !== {MEM_ID_X, 8'd0}) begin errors++; $display("FAIL midrst_restart_addr: got id=%0d addr=%0d required 0/0", mem_id, mem_address); end
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, out_x, out_y} !== {1'b1, 8'd5, 8'd9}) begin errors++; $display("FAIL midrst_restart_pair: got v=%b x=%0d y=%0d required 1/5/9", out_valid, out_x, out_y); end
      wait_done(40, ok);
      @(negedge clk);
      checks++;
      if (!ok || cap_x.size() !== 3) begin errors++; $display("FAIL midrst_complete: got done=%b pairs=%0d required 1/3", ok, cap_x.size()); end
   endtask

   task automatic test_busy_start();
      int d0;
      bit ok;
      load(5, 6, 7, 9, 8, 7);
      count = 8'd3; out_ready = 1'b1;
      cap_x.delete(); cap_y.delete();
      d0 = done_cnt;
      pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL busy_done_timeout: done not seen, required within 40 cycles"); end
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_restart: got busy=%b done_pulses=%0d required 0/1", busy, done_cnt - d0); end
      checks++;
      if (cap_x.size() !== 3) begin errors++; $display("FAIL busy_pair_count: got %0d required 3", cap_x.size()); end
      else begin
         checks++;
         if ({cap_x[0], cap_y[0], cap_x[1], cap_y[1], cap_x[2], cap_y[2]} !== {8'd5, 8'd9, 8'd6, 8'd8, 8'd7, 8'd7}) begin
            errors++;
            $display("FAIL busy_pairs: got (%0d,%0d)(%0d,%0d)(%0d,%0d) required (5,9)(6,8)(7,7)", cap_x[0], cap_y[0], cap_x[1], cap_y[1], cap_x[2], cap_y[2]);
         end
      end
   endtask

   task automatic test_end_marker();
      int d0;
      bit ok;
      load(8'h01, 8'hFF, 8'h03, 8'h02, 8'hFF, 8'h04);
      count = 8'd3; out_ready = 1'b1;
      cap_x.delete(); cap_y.delete();
      d0 = done_cnt;
      pulse_start();
      wait_done(60, ok);
      @(negedge clk);
      checks++;
      if (!ok || done_cnt - d0 !== 1) begin errors++; $display("FAIL marker_done: got seen=%b pulses=%0d required 1/1", ok, done_cnt - d0); end
`ifdef COORD_READER_END_MARKER_EN
      checks++;
      if (cap_x.size() !== 1) begin errors++; $display("FAIL marker_pair_count: got %0d required 1", cap_x.size()); end
      else begin
         checks++;
         if ({cap_x[0], cap_y[0]} !== {8'h01, 8'h02}) begin errors++; $display("FAIL marker_pair: got (%0h,%0h) required (1,2)", cap_x[0], cap_y[0]); end
      end
`else
      checks++;
      if (cap_x.size() !== 3) begin errors++; $display("FAIL marker_pair_count: got %0d required 3", cap_x.size()); end
      else begin
         checks++;
         if ({cap_x[1], cap_y[1], cap_x[2], cap_y[2]} !== {8'hFF, 8'hFF, 8'h03, 8'h04}) begin
            errors++;
            $display("FAIL marker_pairs: got (%0h,%0h)(%0h,%0h) required (ff,ff)(3,4)", cap_x[1], cap_y[1], cap_x[2], cap_y[2]);
         end
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         xmem[i] = 8'd0;
         ymem[i] = 8'd0;
      end
      test_reset();
      test_basic();
      test_zero_count();
      test_stall();
      test_reset_mid();
      test_busy_start();
      test_end_marker();
      checks++;
      if (bus_bad !== 0) begin errors++; $display("FAIL bus_readonly: got %0d cycles with wren/data nonzero required 0", bus_bad); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/coordinate_reader.md
COORDINATE_READER -- requirements
Module: coordinate_reader

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, memory address width; DATA_W, default 8, coordinate component width.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, single-cycle pulse that begins readback when idle.
REQ-005 SHALL have port count, input, ADDR_W, number of stored coordinate pairs, sampled on the accepted start.
REQ-006 SHALL have ports mem_id (output, 3), mem_address (output, ADDR_W), mem_data (output, DATA_W) and mem_wren (output, 1), the master-side memory decoder bus.
REQ-007 SHALL have ports xmem_q and ymem_q, input, DATA_W each, the X and Y memory read data.
REQ-008 SHALL have ports out_x and out_y (output, DATA_W each) and out_valid (output, 1), plus out_ready (input, 1): the coordinate stream handshake.
REQ-009 SHALL have ports busy and done, output, 1 each: busy while reading, done as a single-cycle completion pulse.

Function
REQ-010 SHALL drive mem_wren=0 and mem_data=0 at all times, as the block is read-only.
REQ-011 SHALL implement states IDLE, RD_X, RD_Y, CAP_Y, OUT and FIN.
REQ-012 In IDLE, start=1 SHALL clear index to 0 and latch count; the next state SHALL be FIN if count==0, otherwise RD_X.
REQ-013 In RD_X, the block SHALL drive mem_id=MEM_ID_X and mem_address=index.
REQ-014 In RD_Y, the block SHALL capture xmem_q into the X register and drive mem_id=MEM_ID_Y and mem_address=index, reflecting the memory's one-cycle read latency.
REQ-015 In CAP_Y, the block SHALL capture ymem_q into the Y register, then go to OUT.
REQ-016 In OUT, out_valid SHALL be 1 and out_x/out_y SHALL hold stable until out_valid && out_ready.
REQ-017 On the OUT handshake, the block SHALL go to FIN if index==count-1; otherwise it SHALL increment index and go to RD_X.
REQ-018 In FIN, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start asserted while busy SHALL be ignored.
REQ-021 out_ready asserted outside OUT SHALL have no effect.
REQ-022 The first out_valid SHALL occur 4 cycles after the start cycle, with a minimum of 4 cycles per pair.
REQ-023 count=2^ADDR_W-1 SHALL read addresses 0..254 without index wrap.
REQ-024 In IDLE and FIN, the block SHALL drive mem_id=MEM_ID_X and mem_address=0.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, index=0, latched count=0, X/Y registers=0, out_valid=0, busy=0, done=0, mem_address=0 and mem_id=MEM_ID_X, including mid-operation.
REQ-026 After reset deasserts, the block SHALL wait for a fresh start and SHALL NOT emit partial pairs.

Configuration
REQ-027 With COORD_READER_END_MARKER_EN defined, a captured pair equal to (all-ones, all-ones) SHALL NOT be emitted, and the block SHALL go from CAP_Y directly to FIN.
REQ-028 Without COORD_READER_END_MARKER_EN, the all-ones pair SHALL be emitted like any other pair and only count SHALL terminate readback.

Structure
REQ-029 Package pathfinding_pkg SHALL hold MEM_ID_X=3'd0, MEM_ID_Y=3'd1, ADDR_W, DATA_W, the coord_t struct {x,y} and the reader state enum.
REQ-030 The design SHALL consist of a single module with no sub-module; the FSM and index counter SHALL be in one sequential block.

Verification
REQ-031 Test: preload X={5,6,7} and Y={9,8,7}, count=3, out_ready=1. Required: pairs (5,9),(6,8),(7,7) are emitted; first out_valid occurs at start+4; done pulses once; mem_wren is never 1.
REQ-032 Test: count=0 with start. Required: done occurs at start+1, out_valid is never asserted, busy lasts 1 cycle.
REQ-033 Test: hold out_ready=0 for 10 cycles in OUT. Required: out_valid stays 1, out_x/out_y and index are unchanged, and no memory address advances.
REQ-034 Test: assert reset during RD_Y of pair 2. Required: all outputs are 0 and state is IDLE immediately; a new start re-reads from address 0.
REQ-035 Test: pulse start while busy. Required: no restart and the sequence is unchanged.
REQ-036 Test: with COORD_READER_END_MARKER_EN, X={1,FF,3} and Y={2,FF,4}, count=3. Required: only (1,2) is emitted, then done.
